vga_sprite_engine: RTL and testbench

Parametrised VGA timing generator and sprite compositor, successor to the fixed two-sprite display block. It generates hsync/vsync from configurable timing parameters and composites NUM_SPRITES fixed-priority monochrome sprites over a background colour. Outputs are registered, and sprite attributes are double-buffered so that mid-frame updates from the game logic cannot tear. It drives the VGA pins directly and raises a frame interrupt to the game-logic CPU.

---
 rtl/vga_sprite_engine.sv | 176 +++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// VGA timing generator and fixed-priority monochrome sprite compositor.
// Ports:
//   clk, reset          system clock, async active-high reset
//   sprite_bitmap       per-sprite SPR_SIZE x SPR_SIZE bitmaps (used live)
//   sprite_x/_y         per-sprite top-left corner, 10 bits each
//   sprite_color        per-sprite RGB colour
//   sprite_en           per-sprite enable
//   bg_color            background colour for the visible area (used live)
//   rgb, hsync, vsync   registered VGA pin drivers, one pixel behind counters
//   frame_irq           one-clk pulse on entry to vertical blanking
//   h_count, v_count    current pixel column / line
module vga_sprite_engine #(
    parameter int CLK_DIV          = 2,
    parameter int H_DISPLAY        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_DISPLAY        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int NUM_SPRITES      = 4,
    parameter int SPR_SIZE         = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_SPRITES*SPR_SIZE*SPR_SIZE-1:0] sprite_bitmap,
    input  logic [NUM_SPRITES*10-1:0]               sprite_x,
    input  logic [NUM_SPRITES*10-1:0]               sprite_y,
    input  logic [NUM_SPRITES*3-1:0]                sprite_color,
    input  logic [NUM_SPRITES-1:0]                  sprite_en,
    input  logic [2:0]                              bg_color,
    output logic [2:0]                              rgb,
    output logic                                    hsync,
    output logic                                    vsync,
    output logic                                    frame_irq,
    output logic [9:0]                              h_count,
    output logic [9:0]                              v_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int SQ      = SPR_SIZE * SPR_SIZE;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1;
    localparam int IW      = (SQ > 1) ? $clog2(SQ) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [9:0]    LINE_END = 10'(H_TOTAL - 1);
    localparam logic [9:0]    PAGE_END = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_BEG   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0]    IRQ_LINE = 10'(V_DISPLAY - 1);
    localparam logic          SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

    logic [DW-1:0] div;
    logic          pixel_tick;
    logic          line_end;
    logic          frame_end;

    logic [NUM_SPRITES*10-1:0] sh_x;
    logic [NUM_SPRITES*10-1:0] sh_y;
    logic [NUM_SPRITES*3-1:0]  sh_color;
    logic [NUM_SPRITES-1:0]    sh_en;

    logic [NUM_SPRITES-1:0] hit;
    logic                   visible;
    logic                   hs_act;
    logic                   vs_act;
    logic [2:0]             pix;

    assign pixel_tick = (div == DIV_MAX);
    assign line_end   = (h_count == LINE_END);
    assign frame_end  = line_end && (v_count == PAGE_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            if (pixel_tick) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (pixel_tick) begin
                if (line_end) begin
                    h_count <= '0;
                    v_count <= (v_count == PAGE_END) ? '0 : v_count + 1'b1;
                end else begin
                    h_count <= h_count + 1'b1;
                end
            end
        end
    end

    // Attributes latch only on the last pixel of a frame, so game logic
    // can rewrite them at any time without tearing the picture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_color <= '0;
            sh_en    <= '0;
        end else if (pixel_tick && frame_end) begin
            sh_x     <= sprite_x;
            sh_y     <= sprite_y;
            sh_color <= sprite_color;
            sh_en    <= sprite_en;
        end
    end

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_spr
        logic [10:0]   sx;
        logic [10:0]   sy;
        logic [10:0]   dx;
        logic [10:0]   dy;
        logic [SQ-1:0] bm;
        logic [IW-1:0] idx;

        assign sx = {1'b0, sh_x[s*10 +: 10]};
        assign sy = {1'b0, sh_y[s*10 +: 10]};
        assign dx = {1'b0, h_count} - sx;
        assign dy = {1'b0, v_count} - sy;
        assign bm = sprite_bitmap[s*SQ +: SQ];
        // Only meaningful inside the box, where dx/dy < SPR_SIZE.
        assign idx = IW'(dy[CW-1:0]) * IW'(SPR_SIZE) + IW'(dx[CW-1:0]);

        // 11-bit offsets: counter >= corner plus offset < size is the box
        // test without ever wrapping corner+size.
        assign hit[s] = sh_en[s]
                     && ({1'b0, h_count} >= sx) && (dx < 11'(SPR_SIZE))
                     && ({1'b0, v_count} >= sy) && (dy < 11'(SPR_SIZE))
                     && bm[idx];
    end

    assign visible = (h_count < H_VIS) && (v_count < V_VIS);
    assign hs_act  = (h_count >= HS_BEG) && (h_count < HS_END);
    assign vs_act  = (v_count >= VS_BEG) && (v_count < VS_END);

    // Walk from highest index down so the lowest hitting index wins.
    always_comb begin
        pix = bg_color;
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (hit[s]) begin
                pix = sh_color[s*3 +: 3];
            end
        end
        if (!visible) begin
            pix = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= 3'b000;
            hsync     <= ~SYNC_ON;
            vsync     <= ~SYNC_ON;
            frame_irq <= 1'b0;
        end else begin
            if (pixel_tick) begin
                rgb   <= pix;
                hsync <= hs_act ? SYNC_ON : ~SYNC_ON;
                vsync <= vs_act ? SYNC_ON : ~SYNC_ON;
            end
            frame_irq <= pixel_tick && line_end && (v_count == IRQ_LINE);
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine with a reduced screen geometry.
// Every clock is compared against a pixel-index reference model.
module tb_vga_sprite_engine;

    localparam int CD  = 2;
    localparam int HD  = 40;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 6;
    localparam int VD  = 30;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int SAH = 0;
    localparam int NS  = 4;
    localparam int SZ  = 8;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit ON  = (SAH != 0);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NS*SZ*SZ-1:0]   sprite_bitmap = '0;
    logic [NS*10-1:0]      sprite_x = '0;
    logic [NS*10-1:0]      sprite_y = '0;
    logic [NS*3-1:0]       sprite_color = '0;
    logic [NS-1:0]         sprite_en = '0;
    logic [2:0]            bg_color = 3'b010;
    logic [2:0]            rgb;
    logic                  hsync;
    logic                  vsync;
    logic                  frame_irq;
    logic [9:0]            h_count;
    logic [9:0]            v_count;

    vga_sprite_engine #(
        .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
        .V_BACK(VB), .SYNC_ACTIVE_HIGH(SAH), .NUM_SPRITES(NS),
        .SPR_SIZE(SZ)
    ) dut (
        .clk(clk), .reset(reset), .sprite_bitmap(sprite_bitmap),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_color(sprite_color), .sprite_en(sprite_en),
        .bg_color(bg_color), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .frame_irq(frame_irq), .h_count(h_count), .v_count(v_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: k clocks and T pixels since reset release.
    int       k;
    int       T;
    int       q;
    int       sh_x[NS];
    int       sh_y[NS];
    int       sh_c[NS];
    bit       sh_en[NS];
    logic [2:0] e_rgb;
    logic     e_hs;
    logic     e_vs;
    logic     e_irq;

    function automatic bit in_rng(int a, int lo, int n);
        return (a >= lo) && (a < lo + n);
    endfunction

    function automatic logic [2:0] ref_pix(int h, int v);
        if (h >= HD || v >= VD) return 3'b000;
        for (int s = 0; s < NS; s++) begin
            if (sh_en[s] && in_rng(h, sh_x[s], SZ) && in_rng(v, sh_y[s], SZ)
                && sprite_bitmap[s*SZ*SZ + (v-sh_y[s])*SZ + (h-sh_x[s])])
                return 3'(sh_c[s]);
        end
        return bg_color;
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset) begin
            k = 0;
            T = 0;
            for (int s = 0; s < NS; s++) begin
                sh_x[s] = 0; sh_y[s] = 0; sh_c[s] = 0; sh_en[s] = 0;
            end
            e_rgb = 3'b000;
            e_hs  = !ON;
            e_vs  = !ON;
            e_irq = 1'b0;
        end else begin
            k++;
            e_irq = 1'b0;
            if (k % CD == 0) begin
                q = T;
                T++;
                e_rgb = ref_pix(q % HT, (q / HT) % VT);
                e_hs  = in_rng(q % HT, HD + HF, HS) ? ON : !ON;
                e_vs  = in_rng((q / HT) % VT, VD + VF, VS) ? ON : !ON;
                if (T % FRAME == 0) begin
                    for (int s = 0; s < NS; s++) begin
                        sh_x[s]  = int'(sprite_x[s*10 +: 10]);
                        sh_y[s]  = int'(sprite_y[s*10 +: 10]);
                        sh_c[s]  = int'(sprite_color[s*3 +: 3]);
                        sh_en[s] = sprite_en[s];
                    end
                end
                e_irq = (T % FRAME == VD * HT);
            end
        end
        check("h_count", h_count, T % HT);
        check("v_count", v_count, (T / HT) % VT);
        check("rgb", rgb, e_rgb);
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("frame_irq", frame_irq, e_irq);
    end

    task automatic set_spr(input int s, input int x, input int y,
                           input logic [2:0] c, input logic [SZ*SZ-1:0] bm);
        sprite_x[s*10 +: 10]        = 10'(x);
        sprite_y[s*10 +: 10]        = 10'(y);
        sprite_color[s*3 +: 3]      = c;
        sprite_bitmap[s*SZ*SZ +: SZ*SZ] = bm;
    endtask

    task automatic run_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_attrs();
        for (int s = 0; s < NS; s++) begin
            int x;
            int y;
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                            : int'($urandom_range(0, HD + 2));
            y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                            : int'($urandom_range(0, VD + 2));
            sprite_x[s*10 +: 10]   = 10'(x);
            sprite_y[s*10 +: 10]   = 10'(y);
            sprite_color[s*3 +: 3] = 3'($urandom_range(0, 7));
            sprite_en[s]           = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < NS*SZ*SZ; i++)
            sprite_bitmap[i] = 1'($urandom_range(0, 1));
        bg_color = 3'($urandom_range(0, 7));
    endtask

    logic [SZ*SZ-1:0] one_px;

    initial begin
        one_px = '0;
        one_px[0] = 1'b1;
        set_spr(0, 10, 5, 3'b100, '1);
        set_spr(1, 12, 7, 3'b001, '1);
        sprite_en = 4'b0011;
        run_clks(3);
        reset = 1'b0;

        // Overlap: frame 0 is background only, frame 1 shows sprite 0 on top.
        run_clks(2 * FRAME * CD);
        run_clks(FRAME * CD / 2);
        sprite_en[0] = 1'b0;
        run_clks(3 * FRAME * CD / 2);

        // Clipping at the right/bottom edge, and a far-off sprite.
        set_spr(0, HD - 4, VD - 4, 3'b110, '1);
        set_spr(1, 1023, 1023, 3'b011, '1);
        sprite_en = 4'b0011;
        run_clks(2 * FRAME * CD);

        // Single-pixel bitmap.
        set_spr(2, 3, 3, 3'b101, one_px);
        sprite_en = 4'b0100;
        run_clks(2 * FRAME * CD);

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < HT * CD && (T % HT) != 20; i++)
            @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_h", h_count, 0);
        check("rst_v", v_count, 0);
        check("rst_rgb", rgb, 0);
        check("rst_hs", hsync, !ON);
        check("rst_vs", vsync, !ON);
        check("rst_irq", frame_irq, 0);
        run_clks(3);
        reset = 1'b0;
        run_clks(FRAME * CD + 10);

        // Random attribute rewrites at arbitrary points in the frame.
        repeat (5) begin
            rand_attrs();
            run_clks(int'($urandom_range(1, FRAME * CD)));
        end
        run_clks(FRAME * CD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
